// File: rtl/neuro_sequencer_if.sv
// Signal bundle between neuro_sequencer and its neighbours: scale RAM, image RAM and network core.
// The sequencer takes the master side; the surrounding system or a testbench takes the slave side.
interface neuro_sequencer_if;
  logic        weights_ready;
  logic        frame_ready;
  logic        frame_req;
  logic        scale_re;
  logic [13:0] scale_addr;
  logic [23:0] scale_data;
  logic        img_we;
  logic [15:0] img_addr;
  logic [12:0] img_data;
  logic        net_go;
  logic        net_stop;
  logic [3:0]  net_result;
  logic [1:0]  result;
  logic        result_valid;
  logic        no_majority;
  logic        timeout_err;
  logic        busy;

  modport master (
    input  weights_ready, frame_ready, scale_data, net_stop, net_result,
    output frame_req, scale_re, scale_addr, img_we, img_addr, img_data, net_go,
           result, result_valid, no_majority, timeout_err, busy
  );

  modport slave (
    output weights_ready, frame_ready, scale_data, net_stop, net_result,
    input  frame_req, scale_re, scale_addr, img_we, img_addr, img_data, net_go,
           result, result_valid, no_majority, timeout_err, busy
  );
endinterface

// File: rtl/neuro_sequencer.sv
// Frame sequencer: copies a scaled RGB frame into the network image RAM as three centred planes,
// runs the network, and majority-votes the class over every three completed runs.
module neuro_sequencer #(
  parameter int IMG_W   = 128,
  parameter int IMG_H   = 128,
  parameter int TIMEOUT = 2**26 - 1
) (
  input  logic              clk,
  input  logic              rst,
  neuro_sequencer_if.master bus
);

  localparam int               NPIX      = IMG_W * IMG_H;
  localparam int               CW        = $clog2(TIMEOUT + 1);
  localparam logic [13:0]      LAST_PIX  = 14'(NPIX - 1);
  localparam logic [15:0]      PLANE_SZ  = 16'(NPIX);
  localparam logic [CW-1:0]    RUN_LIMIT = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, LOAD, RUN, VOTE} state_t;

  state_t        state;
  logic          weights_seen;
  logic [1:0]    plane;
  logic [1:0]    wr_plane;
  logic [15:0]   plane_base;
  logic [1:0]    slot_idx;
  logic [1:0]    slot [3];
  logic [CW-1:0] run_cnt;

  logic          frame_req_q;
  logic          scale_re_q;
  logic [13:0]   scale_addr_q;
  logic          img_we_q;
  logic [15:0]   img_addr_q;
  logic [12:0]   img_hold;
  logic          net_go_q;
  logic [1:0]    result_q;
  logic          result_valid_q;
  logic          no_majority_q;
  logic          timeout_err_q;
  logic          busy_q;

  logic [7:0]        chan;
  logic signed [8:0] centered;
  logic [12:0]       pix_val;
  logic              unused_net_result;

  // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    chan = bus.scale_data[7:0];
    if (wr_plane == 2'd1)      chan = bus.scale_data[15:8];
    else if (wr_plane == 2'd2) chan = bus.scale_data[23:16];
  end

  // (c*2 - 255) always fits 9 signed bits, so the modular subtraction below is exact.
  assign centered = $signed({chan, 1'b0}) - 9'sd255;
  assign pix_val  = {centered, 4'b0000};

  // RAM data arrives in the write cycle itself, so the pixel is formed combinationally then held.
  assign bus.img_data = img_we_q ? pix_val : img_hold;

  assign unused_net_result = ^bus.net_result[3:2];

  assign bus.frame_req    = frame_req_q;
  assign bus.scale_re     = scale_re_q;
  assign bus.scale_addr   = scale_addr_q;
  assign bus.img_we       = img_we_q;
  assign bus.img_addr     = img_addr_q;
  assign bus.net_go       = net_go_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.no_majority  = no_majority_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.busy         = busy_q;

  // NOTE: state is updated with non-blocking assignments only, so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      weights_seen   <= 1'b0;
      plane          <= '0;
      wr_plane       <= '0;
      plane_base     <= '0;
      slot_idx       <= '0;
      // NOTE: the vote slots are a tiny register array, not a RAM, so they are cleared in reset like any flop.
      slot           <= '{default: '0};
      run_cnt        <= '0;
      frame_req_q    <= 1'b0;
      scale_re_q     <= 1'b0;
      scale_addr_q   <= '0;
      img_we_q       <= 1'b0;
      img_addr_q     <= '0;
      img_hold       <= '0;
      net_go_q       <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      no_majority_q  <= 1'b0;
      timeout_err_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      frame_req_q    <= 1'b0;
      result_valid_q <= 1'b0;
      no_majority_q  <= 1'b0;
      timeout_err_q  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.weights_ready && !weights_seen) begin
            weights_seen <= 1'b1;
            busy_q       <= 1'b1;
            state        <= REQ;
          end
        end

        REQ: begin
          frame_req_q <= 1'b1;
          state       <= WAIT;
        end

        WAIT: begin
          if (bus.frame_ready) begin
            scale_re_q   <= 1'b1;
            scale_addr_q <= '0;
            plane        <= '0;
            plane_base   <= '0;
            net_go_q     <= 1'b1;
            state        <= LOAD;
          end
        end

        // Issue one read per cycle; the matching write follows one cycle later.
        LOAD: begin
          img_we_q <= scale_re_q;
          if (img_we_q) img_hold <= pix_val;
          if (scale_re_q) begin
            img_addr_q <= plane_base + 16'(scale_addr_q);
            wr_plane   <= plane;
            if (scale_addr_q != LAST_PIX) begin
              scale_addr_q <= scale_addr_q + 14'd1;
            end else if (plane != 2'd2) begin
              scale_addr_q <= '0;
              plane        <= plane + 2'd1;
              plane_base   <= plane_base + PLANE_SZ;
            end else begin
              scale_re_q <= 1'b0;
            end
          end else begin
            run_cnt <= '0;
            state   <= RUN;
          end
        end

        // RUN spans counter values 0..TIMEOUT; a stop on the final value still wins over the abort.
        RUN: begin
          if (bus.net_stop) begin
            slot[slot_idx] <= bus.net_result[1:0];
            net_go_q       <= 1'b0;
            if (slot_idx == 2'd2) begin
              state <= VOTE;
            end else begin
              slot_idx <= slot_idx + 2'd1;
              state    <= REQ;
            end
          end else if (run_cnt == RUN_LIMIT) begin
            net_go_q      <= 1'b0;
            timeout_err_q <= 1'b1;
            state         <= REQ;
          end else begin
            run_cnt <= run_cnt + CW'(1);
          end
        end

        VOTE: begin
          if (slot[0] == slot[1] || slot[0] == slot[2]) begin
            result_q       <= slot[0];
            result_valid_q <= 1'b1;
          end else if (slot[1] == slot[2]) begin
            result_q       <= slot[1];
            result_valid_q <= 1'b1;
          end else begin
            no_majority_q <= 1'b1;
          end
          slot_idx <= '0;
          state    <= REQ;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuro_sequencer.sv
// Scoreboard bench for neuro_sequencer on a small 8x4 image with TIMEOUT=100.
// Stimulus pushes expected writes and pulse events; a negedge monitor pops and compares them.
module tb_neuro_sequencer;

  localparam int IMG_W = 8;
  localparam int IMG_H = 4;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int TMO   = 100;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef enum int {EV_FRAMEREQ, EV_RESULT, EV_NOMAJ, EV_TIMEOUT} ev_kind_t;

  typedef struct {
    ev_kind_t kind;
    int       value;
  } ev_t;

  logic clk;
  logic rst;
  neuro_sequencer_if bus();

  neuro_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] mem [NPIX];

  always @(posedge clk)
    if (bus.scale_re) bus.scale_data <= mem[int'(bus.scale_addr) % NPIX];

  wr_t exp_wr[$];
  ev_t exp_ev[$];
  int  checks   = 0;
  int  failures = 0;
  int  slot_m [3];
  int  idx_m    = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic longint outs();
    return longint'({bus.frame_req, bus.scale_re, bus.scale_addr, bus.img_we, bus.img_addr,
                     bus.img_data, bus.net_go, bus.result, bus.result_valid, bus.no_majority,
                     bus.timeout_err, bus.busy});
  endfunction

  task automatic see_event(input ev_kind_t k, input int v);
    ev_t e;
    if (exp_ev.size() == 0) begin
      fail_now($sformatf("event_unexpected_%s", k.name()));
    end else begin
      e = exp_ev.pop_front();
      check("event_kind", longint'(k), longint'(e.kind));
      if (k == EV_RESULT && e.kind == EV_RESULT) check("vote_result", v, e.value);
    end
  endtask

  // Monitor: every presented write or pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.img_we) begin
        if (exp_wr.size() == 0) begin
          fail_now("img_write_unexpected");
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("img_addr", bus.img_addr, w.addr);
          check("img_data", $signed(bus.img_data), w.data);
        end
      end
      if (bus.result_valid) see_event(EV_RESULT, int'(bus.result));
      if (bus.no_majority)  see_event(EV_NOMAJ, 0);
      if (bus.timeout_err)  see_event(EV_TIMEOUT, 0);
      if (bus.frame_req)    see_event(EV_FRAMEREQ, 0);
    end
  end

  task automatic push_ev(input ev_kind_t k, input int v);
    exp_ev.push_back('{k, v});
  endtask

  task automatic fill_const(input logic [23:0] v);
    for (int p = 0; p < NPIX; p++) mem[p] = v;
  endtask

  task automatic fill_ramp();
    for (int p = 0; p < NPIX; p++)
      mem[p] = {8'(p * 7), 8'(255 - p * 5), 8'(p * 3 + 1)};
  endtask

  // Expected image writes, plane 0=b, 1=g, 2=r, each centred and scaled: (c*2-255)*16.
  task automatic push_frame(input int limit);
    int n;
    int c;
    n = 0;
    for (int pl = 0; pl < 3; pl++) begin
      for (int p = 0; p < NPIX; p++) begin
        c = int'((mem[p] >> (8 * pl)) & 24'hFF);
        if (n < limit) exp_wr.push_back('{pl * NPIX + p, (c * 2 - 255) * 16});
        n++;
      end
    end
  endtask

  task automatic wait_net_go();
    int n;
    n = 0;
    while (!bus.net_go && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!bus.net_go) fail_now("net_go_rise_timeout");
  endtask

  // Returns at the negedge of RUN cycle 0.
  task automatic load_frame(input bit hold_ready, input bit stop_in_load);
    int cnt;
    push_frame(3 * NPIX);
    bus.frame_ready = 1'b1;
    wait_net_go();
    check("load_first_scale_re", bus.scale_re, 1);
    check("load_first_addr", bus.scale_addr, 0);
    if (!hold_ready) bus.frame_ready = 1'b0;
    cnt = 0;
    while ((bus.scale_re || bus.img_we) && cnt < 3 * NPIX + 10) begin
      bus.net_stop = stop_in_load && (cnt == 7);
      cnt++;
      @(negedge clk);
    end
    bus.net_stop = 1'b0;
    check("load_cycles", cnt, 3 * NPIX + 1);
    check("net_go_in_run", bus.net_go, 1);
  endtask

  function automatic int vote(input int a, input int b, input int c);
    if (a == b || a == c) return a;
    if (b == c) return b;
    return -1;
  endfunction

  task automatic run_net(input int delay, input logic [3:0] res);
    int v;
    repeat (delay) @(negedge clk);
    check("net_go_before_stop", bus.net_go, 1);
    bus.net_stop   = 1'b1;
    bus.net_result = res;
    slot_m[idx_m]  = int'(res[1:0]);
    if (idx_m == 2) begin
      v = vote(slot_m[0], slot_m[1], slot_m[2]);
      if (v < 0) push_ev(EV_NOMAJ, 0);
      else       push_ev(EV_RESULT, v);
      idx_m = 0;
    end else begin
      idx_m++;
    end
    push_ev(EV_FRAMEREQ, 0);
    @(negedge clk);
    bus.net_stop    = 1'b0;
    bus.frame_ready = 1'b0;
    check("net_go_after_stop", bus.net_go, 0);
  endtask

  task automatic wait_frame_req();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_req && n < 10);
    if (!bus.frame_req) fail_now("frame_req_timeout");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    bus.weights_ready = 1'b0;
    bus.frame_ready  = 1'b0;
    bus.net_stop     = 1'b0;
    bus.net_result   = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_not_busy", bus.busy, 0);

    // Weights pulse: frame_req two cycles later, one cycle wide.
    push_ev(EV_FRAMEREQ, 0);
    bus.weights_ready = 1'b1;
    @(negedge clk);
    bus.weights_ready = 1'b0;
    check("frame_req_not_yet", bus.frame_req, 0);
    check("busy_after_weights", bus.busy, 1);
    @(negedge clk);
    check("frame_req_pulse", bus.frame_req, 1);
    @(negedge clk);
    check("frame_req_one_cycle", bus.frame_req, 0);

    // Runs 2,1,2 -> result 2; run B ignores a LOAD net_stop and a RUN frame_ready.
    fill_const(24'hFF8000);
    load_frame(1'b0, 1'b0);
    run_net(5, 4'd2);
    wait_frame_req();
    fill_ramp();
    load_frame(1'b1, 1'b1);
    run_net(3, 4'd1);
    wait_frame_req();
    fill_const(24'hFF8000);
    load_frame(1'b0, 1'b0);
    run_net(0, 4'd2);
    wait_frame_req();
    check("result_after_vote", bus.result, 2);

    // Runs 0,1,3 -> no majority, result held.
    fill_ramp();
    load_frame(1'b0, 1'b0);
    run_net(2, 4'd0);
    wait_frame_req();
    load_frame(1'b0, 1'b0);
    run_net(2, 4'd1);
    wait_frame_req();
    load_frame(1'b0, 1'b0);
    run_net(2, 4'd3);
    wait_frame_req();
    check("result_held_no_majority", bus.result, 2);

    // Timeout: no net_stop for RUN cycles 0..100.
    fill_const(24'h102030);
    load_frame(1'b0, 1'b0);
    push_ev(EV_TIMEOUT, 0);
    push_ev(EV_FRAMEREQ, 0);
    repeat (TMO) @(negedge clk);
    check("net_go_at_limit", bus.net_go, 1);
    check("no_timeout_at_limit", bus.timeout_err, 0);
    @(negedge clk);
    check("net_go_after_timeout", bus.net_go, 0);
    check("timeout_err_pulse", bus.timeout_err, 1);
    wait_frame_req();

    // Stop on the limit cycle wins; slot index was left at 0, so 1,3,3 -> result 3.
    load_frame(1'b0, 1'b0);
    run_net(TMO, 4'b1101);
    wait_frame_req();
    load_frame(1'b0, 1'b0);
    run_net(1, 4'd3);
    wait_frame_req();
    load_frame(1'b0, 1'b0);
    run_net(1, 4'd7);
    wait_frame_req();
    check("result_second_pair", bus.result, 3);

    // Reset at pixel 10 of plane 1: writes up to index NPIX+9 happen, nothing after.
    fill_const(24'hFF8000);
    push_frame(NPIX + 10);
    bus.frame_ready = 1'b1;
    wait_net_go();
    for (int k = 0; k < NPIX + 10; k++) @(negedge clk);
    check("abort_point_addr", bus.scale_addr, 10);
    #1 rst = 1'b1;
    #1 check("reset_mid_load_outputs", outs(), 0);
    @(posedge clk);
    #1 check("img_we_after_reset_edge", bus.img_we, 0);
    check("writes_drained_at_abort", exp_wr.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_after_reset_busy", bus.busy, 0);
    check("idle_after_reset_net_go", bus.net_go, 0);
    bus.frame_ready = 1'b0;

    check("events_drained", exp_ev.size(), 0);
    check("writes_drained", exp_wr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
